conv_sched_ctrl: RTL and testbench

//   Sequencing controller for the conv datapath. On start it walks a valid (no padding),

---
 rtl/conv_sched_ctrl_if.sv | 31 +++
 rtl/conv_sched_ctrl.sv | 152 +++++++++++++++
 tb/tb_conv_sched_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_ctrl_if.sv
// Start/base and memory/MAC strobe bundle
// between the conv scheduler and its datapath.
interface conv_sched_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] y_base;
  logic [ADDR_W-1:0] z_base;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] flt_addr;
  logic              rd_en;
  logic              mac_clr;
  logic              mac_en;
  logic [ADDR_W-1:0] out_addr;
  logic              out_we;
  logic              busy;
  logic              done;

  modport master (
    output start, x_base, y_base, z_base,
    input  in_addr, flt_addr, rd_en, mac_clr,
    input  mac_en, out_addr, out_we, busy, done
  );

  modport slave (
    input  start, x_base, y_base, z_base,
    output in_addr, flt_addr, rd_en, mac_clr,
    output mac_en, out_addr, out_we, busy, done
  );
endinterface

// File: rtl/conv_sched_ctrl.sv
// Sequencer for a valid, stride-1 2-D convolution:
// read addresses, MAC strobes, output writes, done.
module conv_sched_ctrl #(
  parameter int IMG_W  = 8,
  parameter int K      = 4,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_sched_ctrl_if.slave bus
);
  localparam int OW = IMG_W - K + 1;
  localparam int CW = $clog2(IMG_W + 1);
  localparam logic [CW-1:0] KM1  = CW'(K - 1);
  localparam logic [CW-1:0] OWM1 = CW'(OW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     i_q, i_d;
  logic [CW-1:0]     j_q, j_d;
  logic [ADDR_W-1:0] x_q, y_q, z_q;
  logic [ADDR_W-1:0] in_addr_q, flt_addr_q, out_addr_q;
  logic              rd_en_q, mac_clr_q, mac_en_q;
  logic              out_we_q, busy_q, done_q;
  logic [ADDR_W-1:0] in_nxt, flt_nxt, out_nxt;

  // Next state and counter advance for the state being left.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAR;
          row_d   = '0;
          col_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_MAC;
        i_d     = '0;
        j_d     = '0;
      end
      S_MAC: begin
        if (j_q == KM1) begin
          j_d = '0;
          if (i_q == KM1) begin
            i_d     = '0;
            state_d = S_DRAIN;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_CLEAR;
        if (col_q == OWM1) begin
          col_d = '0;
          if (row_q == OWM1) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses for the cycle being entered, modulo 2^ADDR_W.
  always_comb begin
    in_nxt = x_q
           + (ADDR_W'(row_d) + ADDR_W'(i_d)) * ADDR_W'(IMG_W)
           + ADDR_W'(col_d) + ADDR_W'(j_d);
    flt_nxt = y_q + ADDR_W'(i_d) * ADDR_W'(K) + ADDR_W'(j_d);
    out_nxt = z_q + ADDR_W'(row_d) * ADDR_W'(OW) + ADDR_W'(col_d);
  end

  // State, counters, latched bases and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      in_addr_q  <= '0;
      flt_addr_q <= '0;
      out_addr_q <= '0;
      rd_en_q    <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_en_q   <= 1'b0;
      out_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      i_q     <= i_d;
      j_q     <= j_d;
      if (state_q == S_IDLE && bus.start) begin
        x_q <= bus.x_base;
        y_q <= bus.y_base;
        z_q <= bus.z_base;
      end
      rd_en_q    <= (state_d == S_MAC);
      in_addr_q  <= (state_d == S_MAC) ? in_nxt : '0;
      flt_addr_q <= (state_d == S_MAC) ? flt_nxt : '0;
      mac_clr_q  <= (state_d == S_CLEAR);
      mac_en_q   <= rd_en_q;
      out_we_q   <= (state_d == S_WRITE);
      out_addr_q <= (state_d == S_WRITE) ? out_nxt : '0;
      busy_q     <= (state_d == S_CLEAR) || (state_d == S_MAC) ||
                    (state_d == S_DRAIN) || (state_d == S_WRITE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign bus.in_addr  = in_addr_q;
  assign bus.flt_addr = flt_addr_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.mac_clr  = mac_clr_q;
  assign bus.mac_en   = mac_en_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_we   = out_we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Directed bench for conv_sched_ctrl: small 3x3/2x2
// instance plus a default 8x8/4x4 instance.
module tb_conv_sched_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_sched_ctrl_if #(.ADDR_W(8)) ifa ();
  conv_sched_ctrl_if #(.ADDR_W(8)) ifb ();

  conv_sched_ctrl #(.IMG_W(3), .K(2), .ADDR_W(8)) ua (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  conv_sched_ctrl #(.IMG_W(8), .K(4), .ADDR_W(8)) ub (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int qin[$];
  int qflt[$];
  int qout[$];
  int qrun[$];
  int run_a = 0, dn_a = 0, done_at_a = 0, st_a = 0;
  int wb = 0, dn_b = 0, done_at_b = 0, st_b = 0;
  int lastin_b = 0, lastout_b = 0;

  logic [7:0] any_a;
  assign any_a = ifa.in_addr | ifa.flt_addr | ifa.out_addr |
                 {2'b0, ifa.rd_en, ifa.mac_clr, ifa.mac_en,
                  ifa.out_we, ifa.busy, ifa.done};

  always @(negedge clk) begin
    if (ifa.rd_en) begin
      qin.push_back(int'(ifa.in_addr));
      qflt.push_back(int'(ifa.flt_addr));
    end
    if (ifa.out_we) qout.push_back(int'(ifa.out_addr));
    if (ifa.mac_en) run_a++;
    else if (run_a != 0) begin
      qrun.push_back(run_a);
      run_a = 0;
    end
    if (ifa.done) begin
      dn_a++;
      done_at_a = ecnt;
    end
    if (ifb.rd_en) lastin_b = int'(ifb.in_addr);
    if (ifb.out_we) begin
      wb++;
      lastout_b = int'(ifb.out_addr);
    end
    if (ifb.done) begin
      dn_b++;
      done_at_b = ecnt;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go_a(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] z);
    qin.delete();
    qflt.delete();
    qout.delete();
    qrun.delete();
    @(negedge clk);
    ifa.x_base = x;
    ifa.y_base = y;
    ifa.z_base = z;
    ifa.start  = 1'b1;
    st_a = ecnt + 1;
    @(negedge clk);
    ifa.start  = 1'b0;
    ifa.x_base = 8'hAA;
    ifa.y_base = 8'h55;
    ifa.z_base = 8'h77;
  endtask

  task automatic wait_a(input int lim);
    int n0;
    n0 = dn_a;
    for (int k = 0; k < lim && dn_a == n0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("done_a_seen", int'(dn_a != n0), 1);
  endtask

  int exp_in[16] = '{16, 17, 19, 20, 17, 18, 20, 21,
                     19, 20, 22, 23, 20, 21, 23, 24};
  int exp_wr[4] = '{254, 255, 1, 2};
  int d0;
  int acc;
  int k5;

  initial begin
    rst_n = 1'b0;
    ifa.start = 1'b0;
    ifa.x_base = '0;
    ifa.y_base = '0;
    ifa.z_base = '0;
    ifb.start = 1'b0;
    ifb.x_base = '0;
    ifb.y_base = '0;
    ifb.z_base = '0;

    // 1: reset and idle
    repeat (2) @(negedge clk);
    chk("reset_outs", int'(any_a), 0);
    rst_n = 1'b1;
    acc = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      acc = acc | int'(any_a);
    end
    chk("idle_quiet", acc, 0);

    // 2: basic run
    go_a(8'd16, 8'd0, 8'd0);
    wait_a(100);
    chk("t2_done_lat", done_at_a - st_a, 28);
    chk("t2_nreads", qin.size(), 16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("t2_in%0d", k), qin[k], exp_in[k]);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_flt%0d", k), qflt[k], k);
    chk("t2_flt15", qflt[15], 3);
    chk("t2_nwr", qout.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_out%0d", k), qout[k], k);
    repeat (3) @(negedge clk);
    chk("t2_nruns", qrun.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_run%0d", k), qrun[k], 4);

    // 3: address wrap, other bases
    go_a(8'd250, 8'd10, 8'd100);
    wait_a(100);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_in%0d", 12 + k), qin[12 + k], exp_wr[k]);
    chk("t3_flt15", qflt[15], 13);
    chk("t3_out3", qout[3], 103);

    // 4: starts while busy are ignored
    d0 = dn_a;
    go_a(8'd16, 8'd0, 8'd0);
    repeat (3) begin
      repeat (5) @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
    end
    repeat (60) @(negedge clk);
    chk("t4_nwr", qout.size(), 4);
    chk("t4_ndone", dn_a - d0, 1);

    // 5: reset in MAC of output 2
    go_a(8'd16, 8'd0, 8'd0);
    k5 = 0;
    while (!(qout.size() == 2 && ifa.rd_en) && k5 < 100) begin
      @(negedge clk);
      #1;
      k5++;
    end
    chk("t5_reach_mac2", int'(k5 < 100), 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_rst_outs", int'(any_a), 0);
    chk("t5_rst_state", int'(ua.state_q), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_no_wr", qout.size(), 2);
    go_a(8'd16, 8'd0, 8'd0);
    wait_a(100);
    chk("t5_nwr", qout.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t5_out%0d", k), qout[k], k);

    // 6: default geometry
    @(negedge clk);
    ifb.x_base = 8'd16;
    ifb.start = 1'b1;
    st_b = ecnt + 1;
    @(negedge clk);
    ifb.start = 1'b0;
    ifb.x_base = 8'hAA;
    k5 = 0;
    while (dn_b == 0 && k5 < 600) begin
      @(negedge clk);
      #1;
      k5++;
    end
    chk("t6_done_seen", dn_b, 1);
    chk("t6_nwr", wb, 25);
    chk("t6_done_lat", done_at_b - st_b, 475);
    chk("t6_last_in", lastin_b, 79);
    chk("t6_last_out", lastout_b, 24);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
